tri_rx_fifo: RTL and testbench
==============================

Name: tri_rx_fifo

Overview:
- Receiving end of the triangle write stream produced by the scene/transform stage (game): accepts 66-bit screen-space triangle words qualified by a one-cycle wen strobe.
- Buffers triangles in a FIFO and presents them to the rasterizer over a valid/ready interface.
- Adds a registered axis-aligned bounding box to each triangle so the rasterizer can limit its scan.
- The producer has no backpressure, so overflow is detected and reported rather than stalled.

Parameters:
- DEPTH, 16, FIFO entries, power of two.
- ADDR_W, 4, log2(DEPTH).
- CNT_W, 16, width of the accepted-triangle counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous reset, active-low; clears all state while 0.
- write_data  input  66  triangle word: [65:56] x0, [55:46] y0, [45:36] x1, [35:26] y1, [25:16] x2, [15:6] y2, [5:0] color; coordinates unsigned 10-bit.
- wen  input  1  write strobe; one word per cycle while high.
- out_ready  input  1  rasterizer accepts the current output.
- clr_ovf  input  1  synchronous clear of overflow.
- out_valid  output  1  out_tri/out_bbox hold a valid triangle.
- out_tri  output  66  triangle, same format as write_data.
- out_bbox  output  40  {xmin, xmax, ymin, ymax}, 10 bits each, unsigned.
- level  output  ADDR_W+1  FIFO occupancy, excluding the output register.
- overflow  output  1  sticky: a word was dropped.
- tri_count  output  CNT_W  words accepted into the FIFO, wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset==0, asynchronous) clears pointers, level, out_valid, overflow and tri_count; out_tri and out_bbox go to 0. An in-flight stream is discarded. The first edge after release behaves as a normal cycle.
- FIFO uses read/write pointers with an extra wrap bit.
  - full: pointers equal modulo DEPTH, wrap bits differ.
  - empty: pointers fully equal.
  - level = wptr - rptr.
- Write, sampled at posedge clk:
  - wen && !full: store write_data at wptr[ADDR_W-1:0], increment wptr, increment tri_count.
  - wen && full: word dropped, overflow set to 1. full is evaluated before any same-cycle pop, so a write while full is dropped even if a pop occurs that edge.
- Output register load condition: !empty && (!out_valid || out_ready).
  - On load: pop the head, set out_tri = head, set out_bbox per the min/max rule below, set out_valid = 1.
  - out_valid && out_ready && empty: out_valid goes to 0; out_tri and out_bbox keep their last value.
  - out_valid && !out_ready: out_tri and out_bbox held stable.
- Bounding box: xmin = min(x0,x1,x2), xmax = max(x0,x1,x2), ymin and ymax likewise; unsigned compare, computed from the FIFO head and registered on load.
- Latency: a word accepted at edge k, with the FIFO empty and the output register empty or being consumed, is visible with out_valid=1 after edge k+1.
- Simultaneous push and pop with 0 < level < DEPTH: both occur and level is unchanged. Push into an empty FIFO cannot pop in the same edge.
- Capacity: with out_ready held low, DEPTH+1 words are absorbed (DEPTH in the FIFO plus 1 in the output register) before dropping.
- overflow clears on clr_ovf=1 at a clock edge unless a drop occurs that same edge; a drop wins.
- color is passed through unmodified. No culling, no reordering; output order equals accepted order.

Test Plan:
- Single word: after reset, wen=1 for 1 cycle with x0=10,y0=20,x1=60,y1=5,x2=30,y2=40,color=6'h3F and out_ready=1 -> out_valid high exactly 1 cycle, starting after edge k+1; out_bbox={10,60,5,40}; tri_count=1; level back to 0.
- Burst: 12 back-to-back words matching the cube stream (offset 270/190, 50-unit faces), out_ready=1 -> 12 outputs in order, no gaps after the first, overflow=0, tri_count=12, maximum level 1.
- Backpressure: out_ready=0 and 18 consecutive writes -> words 1-17 retained, level=16, out_valid=1, word 18 dropped, overflow=1, tri_count=17. Then out_ready=1 -> words 1-17 emerge in order. Then clr_ovf=1 -> overflow=0.
- Drop wins over clear: at full, wen=1 and clr_ovf=1 on the same edge -> overflow remains 1.
- Stall hold: out_valid=1 with out_ready=0 for 5 cycles while writes continue -> out_tri and out_bbox unchanged, level increments by 1 per write.
- Asynchronous reset mid-stream: reset driven low between edges with level=7 -> out_valid, level, overflow and tri_count go to 0 immediately without a clock edge. After release, a new single word -> latency identical to the first scenario.

Source files
------------

// File: rtl/tri_rx_fifo.sv
// Receive-side triangle FIFO: buffers 66-bit triangle words from a producer without backpressure,
// flags overflow, and presents each triangle with a registered bounding box over valid/ready.
module tri_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [65:0]       write_data,
  input  logic              wen,
  input  logic              out_ready,
  input  logic              clr_ovf,
  output logic              out_valid,
  output logic [65:0]       out_tri,
  output logic [39:0]       out_bbox,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [CNT_W-1:0]  tri_count
);

  localparam logic [ADDR_W:0]  PtrOne = 1;
  localparam logic [CNT_W-1:0] CntOne = 1;

  logic [65:0]      mem [DEPTH];
  logic [ADDR_W:0]  wptr_q, wptr_d;
  logic [ADDR_W:0]  rptr_q, rptr_d;
  logic             valid_q, valid_d;
  logic [65:0]      tri_q, tri_d;
  logic [39:0]      bbox_q, bbox_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        full, empty, push, drop, load;
  logic [65:0] head;
  logic [39:0] head_bbox;

  function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Full/empty come from the pre-edge pointers, so a write at full drops even if a pop happens.
  assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                 (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign push  = wen && !full;
  assign drop  = wen && full;
  assign load  = !empty && (!valid_q || out_ready);

  assign head      = mem[rptr_q[ADDR_W-1:0]];
  assign head_bbox = {min3(head[65:56], head[45:36], head[25:16]),
                      max3(head[65:56], head[45:36], head[25:16]),
                      min3(head[55:46], head[35:26], head[15:6]),
                      max3(head[55:46], head[35:26], head[15:6])};

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    valid_d = valid_q;
    tri_d   = tri_q;
    bbox_d  = bbox_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if (push) begin
      wptr_d = wptr_q + PtrOne;
      cnt_d  = cnt_q + CntOne;
    end

    if (load) begin
      rptr_d  = rptr_q + PtrOne;
      tri_d   = head;
      bbox_d  = head_bbox;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= 1'b0;
      tri_q   <= '0;
      bbox_q  <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
      tri_q   <= tri_d;
      bbox_q  <= bbox_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage is not reset: contents are only observable through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q[ADDR_W-1:0]] <= write_data;
    end
  end

  assign out_valid = valid_q;
  assign out_tri   = tri_q;
  assign out_bbox  = bbox_q;
  assign level     = wptr_q - rptr_q;
  assign overflow  = ovf_q;
  assign tri_count = cnt_q;

endmodule

// File: tb/tb_tri_rx_fifo.sv
// Self-checking bench for tri_rx_fifo: directed table, corner-case sequences and random traffic
// against a queue-based reference model.
module tb_tri_rx_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [65:0] write_data = '0;
  logic        wen = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        out_valid;
  logic [65:0] out_tri;
  logic [39:0] out_bbox;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] tri_count;

  int errors = 0;
  int checks = 0;

  tri_rx_fifo #(.DEPTH(16), .ADDR_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .write_data (write_data),
    .wen        (wen),
    .out_ready  (out_ready),
    .clr_ovf    (clr_ovf),
    .out_valid  (out_valid),
    .out_tri    (out_tri),
    .out_bbox   (out_bbox),
    .level      (level),
    .overflow   (overflow),
    .tri_count  (tri_count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending triangles plus the output slot.
  logic [65:0] q[$];
  logic        m_valid;
  logic [65:0] m_tri;
  logic [39:0] m_bbox;
  logic        m_ovf;
  int          m_cnt;

  function automatic logic [65:0] mk(input int x0, input int y0, input int x1, input int y1,
                                     input int x2, input int y2, input int col);
    return {10'(x0), 10'(y0), 10'(x1), 10'(y1), 10'(x2), 10'(y2), 6'(col)};
  endfunction

  function automatic logic [39:0] ref_bbox(input logic [65:0] t);
    int xs[3];
    int ys[3];
    int xmin, xmax, ymin, ymax;
    xs[0] = int'(t[65:56]); ys[0] = int'(t[55:46]);
    xs[1] = int'(t[45:36]); ys[1] = int'(t[35:26]);
    xs[2] = int'(t[25:16]); ys[2] = int'(t[15:6]);
    xmin = 1024; ymin = 1024; xmax = -1; ymax = -1;
    for (int i = 0; i < 3; i++) begin
      if (xs[i] < xmin) xmin = xs[i];
      if (xs[i] > xmax) xmax = xs[i];
      if (ys[i] < ymin) ymin = ys[i];
      if (ys[i] > ymax) ymax = ys[i];
    end
    return {10'(xmin), 10'(xmax), 10'(ymin), 10'(ymax)};
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_tri   = '0;
    m_bbox  = '0;
    m_ovf   = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic compare_all();
    chk("out_valid", 66'(out_valid), 66'(m_valid));
    chk("level", 66'(level), 66'(q.size()));
    chk("overflow", 66'(overflow), 66'(m_ovf));
    chk("tri_count", 66'(tri_count), 66'(m_cnt % 65536));
    chk("out_tri", out_tri, m_tri);
    chk("out_bbox", 66'(out_bbox), 66'(m_bbox));
  endtask

  // Drive inputs, take one edge, advance the model with the same inputs, then compare.
  task automatic step(input logic w, input logic [65:0] d, input logic r, input logic c);
    bit was_full, was_empty;
    wen = w; write_data = d; out_ready = r; clr_ovf = c;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (!was_empty && (!m_valid || r)) begin
      m_tri   = q.pop_front();
      m_bbox  = ref_bbox(m_tri);
      m_valid = 1'b1;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    if (w && !was_full) begin
      q.push_back(d);
      m_cnt++;
    end
    if (w && was_full) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wen = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    reset = 1'b1;
  endtask

  typedef struct {
    logic        w;
    logic [65:0] d;
    logic        r;
    logic        exp_valid;
    int          exp_level;
    int          exp_cnt;
    logic [39:0] exp_bbox;
  } vec_t;

  vec_t tbl[4];

  task automatic run_table(input string tag);
    for (int i = 0; i < 4; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r, 1'b0);
      chk({tag, "_valid"}, 66'(out_valid), 66'(tbl[i].exp_valid));
      chk({tag, "_level"}, 66'(level), 66'(tbl[i].exp_level));
      chk({tag, "_count"}, 66'(tri_count), 66'(tbl[i].exp_cnt));
      chk({tag, "_bbox"}, 66'(out_bbox), 66'(tbl[i].exp_bbox));
    end
  endtask

  initial begin
    logic [65:0] w0, hold_tri;
    logic [39:0] hold_bbox, w0_bbox;
    logic [95:0] rnd;
    int first_v, last_v, nvalid, max_lvl;

    w0      = mk(10, 20, 60, 5, 30, 40, 6'h3F);
    w0_bbox = {10'd10, 10'd60, 10'd5, 10'd40};
    tbl[0] = '{w: 1'b1, d: w0, r: 1'b1, exp_valid: 1'b0, exp_level: 1, exp_cnt: 1, exp_bbox: '0};
    tbl[1] = '{w: 1'b0, d: '0, r: 1'b1, exp_valid: 1'b1, exp_level: 0, exp_cnt: 1,
               exp_bbox: w0_bbox};
    tbl[2] = '{w: 1'b0, d: '0, r: 1'b1, exp_valid: 1'b0, exp_level: 0, exp_cnt: 1,
               exp_bbox: w0_bbox};
    tbl[3] = '{w: 1'b0, d: '0, r: 1'b1, exp_valid: 1'b0, exp_level: 0, exp_cnt: 1,
               exp_bbox: w0_bbox};

    model_reset();
    do_reset();
    chk("reset_valid", 66'(out_valid), 66'(0));
    chk("reset_tri", out_tri, 66'(0));

    // Single word latency.
    run_table("single");

    // Cube burst, always ready.
    do_reset();
    first_v = -1; last_v = -1; nvalid = 0; max_lvl = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 12) begin
        int bx, by;
        bx = 270 + (i % 4) * 50;
        by = 190 + (i / 4) * 50;
        if (i % 2 == 0) step(1'b1, mk(bx, by, bx + 50, by, bx, by + 50, i), 1'b1, 1'b0);
        else step(1'b1, mk(bx + 50, by, bx + 50, by + 50, bx, by + 50, i), 1'b1, 1'b0);
      end else begin
        step(1'b0, '0, 1'b1, 1'b0);
      end
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (out_valid) begin
        nvalid++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
    end
    chk("burst_outputs", 66'(nvalid), 66'(12));
    chk("burst_contiguous", 66'(last_v - first_v + 1), 66'(12));
    chk("burst_max_level", 66'(max_lvl), 66'(1));
    chk("burst_overflow", 66'(overflow), 66'(0));
    chk("burst_count", 66'(tri_count), 66'(12));

    // Backpressure: 18 writes, then drop-wins-over-clear, drain, clear.
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, mk(i, i + 1, i + 2, 3, 4, 5, i), 1'b0, 1'b0);
    chk("bp_level", 66'(level), 66'(16));
    chk("bp_valid", 66'(out_valid), 66'(1));
    chk("bp_overflow", 66'(overflow), 66'(1));
    chk("bp_count", 66'(tri_count), 66'(17));
    step(1'b1, mk(99, 99, 99, 99, 99, 99, 1), 1'b0, 1'b1);
    chk("drop_wins_clear", 66'(overflow), 66'(1));
    chk("drop_count", 66'(tri_count), 66'(17));
    for (int i = 0; i < 19; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drain_valid", 66'(out_valid), 66'(0));
    chk("drain_last", out_tri[5:0], 66'(16));
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr_ovf", 66'(overflow), 66'(0));

    // Stall hold while writes continue.
    do_reset();
    step(1'b1, w0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    hold_tri = out_tri;
    hold_bbox = out_bbox;
    chk("stall_loaded", 66'(out_valid), 66'(1));
    for (int i = 0; i < 5; i++) begin
      step(1'b1, mk(500 + i, 1, 2, 3, 4, 5, 9), 1'b0, 1'b0);
      chk("stall_tri", out_tri, w0);
      chk("stall_bbox", 66'(out_bbox), 66'(w0_bbox));
      chk("stall_level", 66'(level), 66'(i + 1));
    end
    chk("stall_hold_tri", out_tri, hold_tri);
    chk("stall_hold_bbox", 66'(out_bbox), 66'(hold_bbox));

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, mk(i, 2, 3, 4, 5, 6, i), 1'b0, 1'b0);
    chk("pre_areset_level", 66'(level), 66'(7));
    wen = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("areset_valid", 66'(out_valid), 66'(0));
    chk("areset_level", 66'(level), 66'(0));
    chk("areset_overflow", 66'(overflow), 66'(0));
    chk("areset_count", 66'(tri_count), 66'(0));
    model_reset();
    #2 reset = 1'b1;
    run_table("after_areset");

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, rnd[65:0],
           ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
